// File: rtl/eg_lp_pkg.sv
// ---------------------------------------------------------------------------
// eg_lp_pkg
// Shared types and constants for the AXI low-power clock controller:
//   - lp_state_e : controller state encoding
//   - IDLE_CNT_W : idle counter width (covers IDLE_CYCLES range 1..255)
//   - DENY_CNT_W : width of the saturating denial counter
//   - sat_inc8   : saturating 8-bit increment helper
// ---------------------------------------------------------------------------
package eg_lp_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    REQ       = 2'b01,
    LOW_POWER = 2'b10,
    EXIT      = 2'b11
  } lp_state_e;

  localparam int IDLE_CNT_W = 8;
  localparam int DENY_CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/eg_lp_clk_ctrl_if.sv
// ---------------------------------------------------------------------------
// eg_lp_clk_ctrl_if
// Low-power handshake bundle between the system clock controller and one
// gated AXI peripheral.
//   master : the controller (drives csysreq, clk_en, low_power, denied,
//            deny_cnt; observes lp_enable, wake_req, cactive, csysack)
//   slave  : the peripheral / system side driving the inputs
// ---------------------------------------------------------------------------
interface eg_lp_clk_ctrl_if;
  import eg_lp_pkg::*;

  logic                  lp_enable;
  logic                  wake_req;
  logic                  cactive;
  logic                  csysack;
  logic                  csysreq;
  logic                  clk_en;
  logic                  low_power;
  logic                  denied;
  logic [DENY_CNT_W-1:0] deny_cnt;

  modport master (
    input  lp_enable, wake_req, cactive, csysack,
    output csysreq, clk_en, low_power, denied, deny_cnt
  );

  modport slave (
    output lp_enable, wake_req, cactive, csysack,
    input  csysreq, clk_en, low_power, denied, deny_cnt
  );

endinterface

// File: rtl/eg_lp_idle_cnt.sv
// ---------------------------------------------------------------------------
// eg_lp_idle_cnt
// Clearable, saturating idle-cycle counter with terminal-count flag.
//   clk_i   : free-running clock
//   rst_i   : synchronous active-high reset
//   clr_i   : clear to zero (has priority over inc_i)
//   inc_i   : count one idle cycle
//   tc_o    : counter currently equals TERMINAL
// ---------------------------------------------------------------------------
module eg_lp_idle_cnt
  import eg_lp_pkg::*;
#(
  parameter int unsigned TERMINAL = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [IDLE_CNT_W-1:0] cnt_q;
  logic [IDLE_CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {IDLE_CNT_W{1'b0}};
    end else if (inc_i) begin
      cnt_d = sat_inc8(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {IDLE_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TERMINAL[IDLE_CNT_W-1:0]);

endmodule

// File: rtl/eg_lp_clk_ctrl.sv
// ---------------------------------------------------------------------------
// eg_lp_clk_ctrl
// System-side AXI low-power controller: requests low power after a run of
// idle cycles, gates the peripheral clock once the peripheral accepts, and
// wakes it on demand. Denials are pulsed and counted (saturating).
//   aclk_i    : free-running system clock (never gated here)
//   areset_i  : synchronous active-high reset
//   lp_if     : handshake bundle (master side), see eg_lp_clk_ctrl_if
// Parameter IDLE_CYCLES (1..255): consecutive idle cycles before request.
// ---------------------------------------------------------------------------
module eg_lp_clk_ctrl
  import eg_lp_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic              aclk_i,
  input  logic              areset_i,
  eg_lp_clk_ctrl_if.master  lp_if
);

  lp_state_e             state_q, state_d;
  logic                  idle_s;
  logic                  tc_s;
  logic                  cnt_clr_s;
  logic                  deny_s;
  logic                  csysreq_q, clk_en_q, low_power_q, denied_q;
  logic [DENY_CNT_W-1:0] deny_cnt_q, deny_cnt_d;

  assign idle_s    = ~lp_if.cactive & lp_if.lp_enable & ~lp_if.wake_req;
  // Counter only runs in RUN; any other state leaves it cleared so RUN is
  // always re-entered with a fresh count.
  assign cnt_clr_s = (state_q != RUN) | ~idle_s;

  eg_lp_idle_cnt #(
    .TERMINAL (IDLE_CYCLES - 32'd1)
  ) u_idle_cnt (
    .clk_i (aclk_i),
    .rst_i (areset_i),
    .clr_i (cnt_clr_s),
    .inc_i (idle_s),
    .tc_o  (tc_s)
  );

  // Next-state and denial decode; REQ priority is abort > deny > enter.
  always_comb begin
    state_d    = state_q;
    deny_s     = 1'b0;
    deny_cnt_d = deny_cnt_q;
    case (state_q)
      RUN: begin
        if (idle_s && tc_s) begin
          state_d = REQ;
        end else begin
          state_d = RUN;
        end
      end
      REQ: begin
        if (lp_if.csysack) begin
          state_d = REQ;
        end else if (lp_if.wake_req || !lp_if.lp_enable) begin
          state_d = EXIT;
        end else if (lp_if.cactive) begin
          state_d    = EXIT;
          deny_s     = 1'b1;
          deny_cnt_d = sat_inc8(deny_cnt_q);
        end else begin
          state_d = LOW_POWER;
        end
      end
      LOW_POWER: begin
        if (lp_if.wake_req || lp_if.cactive || !lp_if.lp_enable) begin
          state_d = EXIT;
        end else begin
          state_d = LOW_POWER;
        end
      end
      EXIT: begin
        if (lp_if.csysack) begin
          state_d = RUN;
        end else begin
          state_d = EXIT;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state
  // so they change on the same edge as the state itself.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q     <= RUN;
      csysreq_q   <= 1'b1;
      clk_en_q    <= 1'b1;
      low_power_q <= 1'b0;
      denied_q    <= 1'b0;
      deny_cnt_q  <= {DENY_CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      csysreq_q   <= (state_d == RUN) || (state_d == EXIT);
      clk_en_q    <= (state_d != LOW_POWER);
      low_power_q <= (state_d == LOW_POWER);
      denied_q    <= deny_s;
      deny_cnt_q  <= deny_cnt_d;
    end
  end

  assign lp_if.csysreq   = csysreq_q;
  assign lp_if.clk_en    = clk_en_q;
  assign lp_if.low_power = low_power_q;
  assign lp_if.denied    = denied_q;
  assign lp_if.deny_cnt  = deny_cnt_q;

endmodule

// File: tb/tb_eg_lp_clk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_eg_lp_clk_ctrl
// Two controllers (IDLE_CYCLES=4 and the boundary IDLE_CYCLES=1) driven by
// randomized traffic and compared every cycle against a behavioural model.
// Each controller has its own peripheral model that lets CSYSACK follow
// CSYSREQ after a random delay.
// ---------------------------------------------------------------------------
module tb_eg_lp_clk_ctrl;

  localparam int unsigned IC0 = 4;
  localparam int unsigned IC1 = 1;

  // Model modes (behavioural, not tied to RTL encoding).
  localparam int M_RUN  = 0;
  localparam int M_REQ  = 1;
  localparam int M_LP   = 2;
  localparam int M_EXIT = 3;

  logic clk = 1'b0;
  logic areset;

  eg_lp_clk_ctrl_if if0 ();
  eg_lp_clk_ctrl_if if1 ();

  eg_lp_clk_ctrl #(.IDLE_CYCLES(IC0)) dut0 (
    .aclk_i   (clk),
    .areset_i (areset),
    .lp_if    (if0)
  );

  eg_lp_clk_ctrl #(.IDLE_CYCLES(IC1)) dut1 (
    .aclk_i   (clk),
    .areset_i (areset),
    .lp_if    (if1)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;

  // Model state per controller.
  int   mode     [2];
  int   run_len  [2];   // consecutive idle cycles seen in RUN
  int   m_dcnt   [2];
  bit   m_den    [2];
  int   idle_tgt [2];

  // Stimulus.
  logic lp_en, wake, cact;
  logic ack [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input int i, input logic req, input logic ce,
                           input logic lp, input logic den, input logic [7:0] dc);
    logic e_req, e_ce, e_lp;
    e_req = (mode[i] == M_RUN) || (mode[i] == M_EXIT);
    e_ce  = (mode[i] != M_LP);
    e_lp  = (mode[i] == M_LP);
    chk($sformatf("d%0d_csysreq", i),  {7'd0, req}, {7'd0, e_req});
    chk($sformatf("d%0d_clken", i),    {7'd0, ce},  {7'd0, e_ce});
    chk($sformatf("d%0d_lowpower", i), {7'd0, lp},  {7'd0, e_lp});
    chk($sformatf("d%0d_denied", i),   {7'd0, den}, {7'd0, m_den[i]});
    chk($sformatf("d%0d_denycnt", i),  dc,          8'(m_dcnt[i]));
  endtask

  // Advance the model by one clock using the inputs about to be applied.
  task automatic model_step();
    bit idle;
    idle = !cact && lp_en && !wake;
    for (int i = 0; i < 2; i++) begin
      if (areset) begin
        mode[i]    = M_RUN;
        run_len[i] = 0;
        m_dcnt[i]  = 0;
        m_den[i]   = 1'b0;
      end else begin
        m_den[i] = 1'b0;
        case (mode[i])
          M_RUN: begin
            if (idle) begin
              run_len[i]++;
              if (run_len[i] >= idle_tgt[i]) begin
                mode[i]    = M_REQ;
                run_len[i] = 0;
              end
            end else begin
              run_len[i] = 0;
            end
          end
          M_REQ: begin
            if (!ack[i]) begin
              if (wake || !lp_en) begin
                mode[i] = M_EXIT;
              end else if (cact) begin
                mode[i]  = M_EXIT;
                m_den[i] = 1'b1;
                if (m_dcnt[i] < 255) m_dcnt[i]++;
              end else begin
                mode[i] = M_LP;
              end
            end
          end
          M_LP: begin
            if (wake || cact || !lp_en) mode[i] = M_EXIT;
          end
          default: begin
            if (ack[i]) begin
              mode[i]    = M_RUN;
              run_len[i] = 0;
            end
          end
        endcase
      end
    end
  endtask

  // Peripheral: acknowledge follows the current request after a random lag.
  task automatic peripheral();
    for (int i = 0; i < 2; i++) begin
      if ($urandom_range(0, 1) == 0)
        ack[i] = (mode[i] == M_RUN) || (mode[i] == M_EXIT);
    end
  endtask

  // Apply inputs, advance model, then check outputs after the edge.
  task automatic tick();
    if0.lp_enable = lp_en;  if1.lp_enable = lp_en;
    if0.wake_req  = wake;   if1.wake_req  = wake;
    if0.cactive   = cact;   if1.cactive   = cact;
    if0.csysack   = ack[0]; if1.csysack   = ack[1];
    model_step();
    @(negedge clk);
    check_dut(0, if0.csysreq, if0.clk_en, if0.low_power, if0.denied, if0.deny_cnt);
    check_dut(1, if1.csysreq, if1.clk_en, if1.low_power, if1.denied, if1.deny_cnt);
  endtask

  initial begin
    idle_tgt[0] = int'(IC0);
    idle_tgt[1] = int'(IC1);
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_RUN; run_len[i] = 0; m_dcnt[i] = 0; m_den[i] = 1'b0;
      ack[i]  = 1'b1;
    end
    lp_en = 1'b0; wake = 1'b0; cact = 1'b0;

    // Reset state.
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;

    // Random traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      areset = ($urandom_range(0, 499) == 0);
      lp_en  = ($urandom_range(0, 7) != 0);
      wake   = ($urandom_range(0, 15) == 0);
      cact   = ($urandom_range(0, 9) == 0);
      peripheral();
      tick();
    end

    // Forced denials: activity appears whenever controller 0 is requesting.
    areset = 1'b0; lp_en = 1'b1; wake = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      cact = (mode[0] == M_REQ);
      peripheral();
      tick();
    end
    chk("deny_sat", if0.deny_cnt, 8'd255);

    // Drive controller 0 into low power, then reset there.
    cact = 1'b0;
    for (int c = 0; c < 300 && mode[0] != M_LP; c++) begin
      peripheral();
      tick();
    end
    chk("reach_lp", {7'd0, if0.low_power}, 8'd1);
    for (int c = 0; c < 3; c++) tick();
    areset = 1'b1;
    tick();
    chk("rst_csysreq", {7'd0, if0.csysreq},   8'd1);
    chk("rst_clken",   {7'd0, if0.clk_en},    8'd1);
    chk("rst_lowpwr",  {7'd0, if0.low_power}, 8'd0);
    chk("rst_denycnt", if0.deny_cnt,          8'd0);
    areset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      peripheral();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eg_lp_clk_ctrl.md
# eg_lp_clk_ctrl

System-side controller for the AXI low-power interface: it drives CSYSREQ to a peripheral's low-power port, watches CSYSACK and CACTIVE, and gates the peripheral clock once entry is accepted. It sits in the free-running ACLK domain of the system clock controller, one instance per gated AXI slave. It provides automatic idle-driven entry, denial handling, and wake-on-request exit.

## Interface
- IDLE_CYCLES, 16: consecutive idle cycles before requesting low power; legal range 1..255.
- ACLK  in  1  free-running system clock; never gated by this block.
- ARESET  in  1  synchronous, active-high reset.
- LpEnable  in  1  permits automatic low-power entry.
- WakeReq  in  1  level; pending traffic for the peripheral; forces/holds run mode.
- CACTIVE  in  1  peripheral active indication.
- CSYSACK  in  1  peripheral low-power acknowledge.
- CSYSREQ  out  1  low-power request to peripheral; 0 = request low power.
- ClkEn  out  1  enable to the peripheral clock-gating cell.
- LowPower  out  1  high while the peripheral is in the low-power state.
- Denied  out  1  one-cycle pulse when the peripheral refuses entry.
- DenyCnt  out  8  saturating count of denials.

## Operation
- All outputs are registered. Reset values: CSYSREQ=1, ClkEn=1, LowPower=0, Denied=0, DenyCnt=0, state RUN, idle counter 0.
- Idle condition: CACTIVE=0 & LpEnable=1 & WakeReq=0.
- RUN: CSYSREQ=1, ClkEn=1.
  - On each cycle the idle condition is false, clear the idle counter.
  - Otherwise increment the idle counter, saturating.
  - When the idle condition holds and the counter equals IDLE_CYCLES-1, go to REQ.
- REQ: CSYSREQ=0; wait for CSYSACK=0. CSYSREQ must not change before CSYSACK matches it. When CSYSACK=0:
  - WakeReq=1 or LpEnable=0: go to EXIT (abort; not a denial).
  - Else CACTIVE=1: go to EXIT, pulse Denied, increment DenyCnt (saturate at 255).
  - Else: go to LOW_POWER.
- LOW_POWER: ClkEn=0, LowPower=1, CSYSREQ=0. Exit to EXIT on WakeReq=1, CACTIVE=1, or LpEnable=0.
- EXIT: CSYSREQ=1, ClkEn=1, LowPower=0; wait for CSYSACK=1, then go to RUN with the idle counter cleared.
- Priority inside REQ: abort over deny over enter.

## Timing
- First idle cycle is cycle 0. CSYSREQ is first low in cycle IDLE_CYCLES when idle is continuous. With IDLE_CYCLES=1, CSYSREQ falls in the cycle after the first idle cycle.
- Entry: CSYSACK sampled low in cycle n gives ClkEn=0 and LowPower=1 from cycle n+1.
- Exit: wake seen in cycle n gives CSYSREQ=1 and ClkEn=1 together from cycle n+1. The peripheral clock is running before it must respond.
- Denied is high only in cycle n+1 for a denial sampled in cycle n.
- CSYSACK that stays high in REQ holds REQ indefinitely; there is no timeout. CSYSACK that stays low in EXIT holds EXIT.
- Any idle break in RUN (one cycle of CACTIVE=1) restarts the full count.
- Reset in any state returns all outputs to reset values on the next edge. This includes re-enabling the clock from LOW_POWER.
- Changes to IDLE_CYCLES take effect only at elaboration.

## Structure
- Package eg_lp_pkg holds:
  - State encoding constants: RUN=2'b00, REQ=2'b01, LOW_POWER=2'b10, EXIT=2'b11.
  - Idle-counter width rule: 8 bits, covering the IDLE_CYCLES range.
  - DenyCnt width: 8.
- Sub-module eg_lp_idle_cnt contains the clearable, saturating idle counter with a terminal-count output. The FSM and the deny counter stay in the top level.

## Test plan
- Entry with IDLE_CYCLES=4, LpEnable=1, CACTIVE=0, CSYSACK following CSYSREQ after 2 cycles:
  - CSYSREQ falls in cycle 4.
  - ClkEn=0 and LowPower=1 one cycle after CSYSACK=0.
  - Denied stays 0.
- Denial: CACTIVE rises while in REQ and is high when CSYSACK=0:
  - Denied pulses one cycle, DenyCnt=1.
  - CSYSREQ returns to 1, ClkEn stays 1.
  - RUN is re-entered after CSYSACK=1.
- Wake from LOW_POWER: WakeReq=1 in cycle n:
  - CSYSREQ=1 and ClkEn=1 in cycle n+1, LowPower=0.
  - RUN after CSYSACK=1, idle counter restarts at 0.
- Idle restart: CACTIVE pulses high for one cycle at idle count 2 (IDLE_CYCLES=4) → CSYSREQ falls 4 cycles after CACTIVE returns low.
- Abort and saturation:
  - WakeReq=1 during REQ: REQ holds until CSYSACK=0, then goes to EXIT with no Denied.
  - 300 forced denials: DenyCnt holds at 255.
- ARESET asserted in LOW_POWER: next cycle CSYSREQ=1, ClkEn=1, LowPower=0, DenyCnt=0.
